// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory stage of the 5-stage pipeline.
// Sits between the EX/MEM latch outputs and the MEM/WB latch. The MEM/WB
// state is held inside this block.
//   - Issues a request to a multi-cycle data memory (mem_rd/mem_wr/mem_addr/
//     mem_wdata) and waits for mem_done.
//   - Raises stall_out while the access is pending, which freezes EX/MEM and
//     the stages above it.
//   - Emits a one-cycle mem_createdump pulse for DMemDump and then halts.
//   - Flags misaligned word accesses and memory timeouts through the sticky
//     err and halted outputs.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid, *_in                EX/MEM entry (control bits, address/ALU
//                                 result, store data, PC+2, destination)
//   mem_addr/wdata/rd/wr          data memory request
//   mem_createdump                dump pulse to data memory
//   mem_rdata, mem_done           memory response
//   stall_out                     upstream hold
//   wb_*                          registered MEM/WB bundle
//   err, halted                   sticky fatal error / halt flags
module mem_stage_ctrl #(
  parameter int TIMEOUT     = 16,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        DMemEn_in,
  input  logic        DMemWrite_in,
  input  logic        DMemDump_in,
  input  logic [15:0] aluOutput_in,
  input  logic [15:0] B_in,
  input  logic [15:0] updatedPC_in,
  input  logic [2:0]  WriteRegister_in,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_createdump,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall_out,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic        wb_MemToReg,
  output logic [15:0] wb_readData,
  output logic [15:0] wb_aluOutput,
  output logic [15:0] wb_updatedPC,
  output logic [2:0]  wb_WriteRegister,
  output logic        err,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] hold_addr_q, hold_addr_d;
  logic [15:0] hold_wdata_q, hold_wdata_d;
  logic        hold_wr_q, hold_wr_d;
  logic        err_q, err_d, halted_q, halted_d;
  logic        wbv_q, wbv_d, wbrw_q, wbrw_d, wbm2r_q, wbm2r_d;
  logic [15:0] wbrd_q, wbrd_d, wbalu_q, wbalu_d, wbpc_q, wbpc_d;
  logic [2:0]  wbwr_q, wbwr_d;

  logic access, misalign, dump;
  assign access   = ex_valid & DMemEn_in & ~DMemDump_in;
  assign misalign = (ALIGN_CHECK != 0) & aluOutput_in[0];
  assign dump     = ex_valid & DMemDump_in;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hold_addr_d    = hold_addr_q;
    hold_wdata_d   = hold_wdata_q;
    hold_wr_d      = hold_wr_q;
    err_d          = err_q;
    halted_d       = halted_q;
    wbv_d          = 1'b0;
    wbrw_d         = wbrw_q;
    wbm2r_d        = wbm2r_q;
    wbrd_d         = wbrd_q;
    wbalu_d        = wbalu_q;
    wbpc_d         = wbpc_q;
    wbwr_d         = wbwr_q;
    mem_addr       = 16'h0000;
    mem_wdata      = 16'h0000;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_createdump = 1'b0;
    stall_out      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (dump) begin
          mem_createdump = 1'b1;
          stall_out      = 1'b1;
          halted_d       = 1'b1;
          state_d        = HALT;
        end else if (access && misalign) begin
          // Hold upstream: the machine is going down and the faulting
          // instruction must not be replaced.
          stall_out = 1'b1;
          err_d     = 1'b1;
          halted_d  = 1'b1;
          state_d   = HALT;
        end else if (access) begin
          mem_addr     = aluOutput_in;
          mem_wdata    = B_in;
          mem_rd       = ~DMemWrite_in;
          mem_wr       = DMemWrite_in;
          hold_addr_d  = aluOutput_in;
          hold_wdata_d = B_in;
          hold_wr_d    = DMemWrite_in;
          if (mem_done) begin
            wbv_d   = 1'b1;
            wbrw_d  = RegWrite_in;
            wbm2r_d = MemToReg_in;
            wbalu_d = aluOutput_in;
            wbpc_d  = updatedPC_in;
            wbwr_d  = WriteRegister_in;
            wbrd_d  = DMemWrite_in ? 16'h0000 : mem_rdata;
          end else begin
            stall_out = 1'b1;
            cnt_d     = 8'd1;
            state_d   = WAIT;
          end
        end else begin
          // Pass-through; bubbles also reload the bundle with wb_valid=0.
          wbv_d   = ex_valid;
          wbrw_d  = RegWrite_in;
          wbm2r_d = MemToReg_in;
          wbalu_d = aluOutput_in;
          wbpc_d  = updatedPC_in;
          wbwr_d  = WriteRegister_in;
          wbrd_d  = 16'h0000;
        end
      end

      WAIT: begin
        mem_addr  = hold_addr_q;
        mem_wdata = hold_wdata_q;
        mem_rd    = ~hold_wr_q;
        mem_wr    = hold_wr_q;
        stall_out = ~mem_done;
        if (mem_done) begin
          // EX/MEM is frozen, so *_in still describe the pending instruction.
          wbv_d   = 1'b1;
          wbrw_d  = RegWrite_in;
          wbm2r_d = MemToReg_in;
          wbalu_d = aluOutput_in;
          wbpc_d  = updatedPC_in;
          wbwr_d  = WriteRegister_in;
          wbrd_d  = hold_wr_q ? 16'h0000 : mem_rdata;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (cnt_q == TO) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        stall_out = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      hold_addr_q  <= 16'h0000;
      hold_wdata_q <= 16'h0000;
      hold_wr_q    <= 1'b0;
      err_q        <= 1'b0;
      halted_q     <= 1'b0;
      wbv_q        <= 1'b0;
      wbrw_q       <= 1'b0;
      wbm2r_q      <= 1'b0;
      wbrd_q       <= 16'h0000;
      wbalu_q      <= 16'h0000;
      wbpc_q       <= 16'h0000;
      wbwr_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_wr_q    <= hold_wr_d;
      err_q        <= err_d;
      halted_q     <= halted_d;
      wbv_q        <= wbv_d;
      wbrw_q       <= wbrw_d;
      wbm2r_q      <= wbm2r_d;
      wbrd_q       <= wbrd_d;
      wbalu_q      <= wbalu_d;
      wbpc_q       <= wbpc_d;
      wbwr_q       <= wbwr_d;
    end
  end

  assign wb_valid         = wbv_q;
  assign wb_RegWrite      = wbrw_q;
  assign wb_MemToReg      = wbm2r_q;
  assign wb_readData      = wbrd_q;
  assign wb_aluOutput     = wbalu_q;
  assign wb_updatedPC     = wbpc_q;
  assign wb_WriteRegister = wbwr_q;
  assign err              = err_q;
  assign halted           = halted_q;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage of the 5-stage pipeline, between the EX/MEM latch outputs and the MEM/WB latch.
- Drives a multi-cycle data memory through a request/done handshake and stalls upstream while an access is pending.
- Registers the writeback bundle: the MEM/WB state lives inside this block.
- Handles DMemDump (halt) and flags fatal memory errors.

Parameters:
- TIMEOUT, 16: WAIT cycles without mem_done before err is raised. Valid range 2..255.
- ALIGN_CHECK, 1: when 1, a word access with address bit 0 set is an error.

Ports:
- clk in 1: system clock, rising edge.
- rst in 1: synchronous, active-high reset.
- ex_valid in 1: EX/MEM entry holds a real instruction (0 = bubble).
- RegWrite_in, MemToReg_in, DMemEn_in, DMemWrite_in, DMemDump_in in 1 each: control bits from EX/MEM.
- aluOutput_in in 16: memory address, or ALU result.
- B_in in 16: store data.
- updatedPC_in in 16: PC+2 for link writeback.
- WriteRegister_in in 3: destination register.
- mem_addr out 16; mem_wdata out 16; mem_rd out 1; mem_wr out 1: data memory request.
- mem_createdump out 1: one-cycle dump pulse to data memory.
- mem_rdata in 16; mem_done in 1: memory response; done is valid in the cycle the access completes.
- stall_out out 1: holds EX/MEM and upstream stages (their en = ~stall_out).
- wb_valid, wb_RegWrite, wb_MemToReg out 1 each.
- wb_readData, wb_aluOutput, wb_updatedPC out 16 each.
- wb_WriteRegister out 3.
- err out 1: sticky fatal error.
- halted out 1: sticky, processor halted.

Behaviour:
- Reset: state=IDLE, wait counter=0, every registered output 0 (wb_*, err, halted). With state IDLE and no valid request, mem_rd, mem_wr, mem_createdump and stall_out are also 0. rst overrides all other inputs in the same edge.
- access = ex_valid & DMemEn_in & ~DMemDump_in.
- misalign = ALIGN_CHECK & aluOutput_in[0].
- States: IDLE, WAIT, HALT.
- IDLE, no access, no dump: pass-through.
  - Next edge: wb_valid=ex_valid; wb_* load their *_in values; wb_readData=0.
  - Latency 1 cycle. stall_out=0.
- IDLE, access & ~misalign: request issues combinationally in the same cycle.
  - mem_addr=aluOutput_in, mem_wdata=B_in, mem_rd=~DMemWrite_in, mem_wr=DMemWrite_in.
  - Address and data are also captured into internal hold registers.
  - mem_done=1 in this cycle: completes as pass-through, with wb_readData=mem_rdata for reads, 0 for writes. stall_out=0.
  - mem_done=0: stall_out=1, next edge goes to WAIT, counter=1, wb_valid=0 (bubble to WB).
- WAIT:
  - mem_rd/mem_wr/mem_addr/mem_wdata driven from the hold registers, stable until done.
  - stall_out=~mem_done. EX/MEM is frozen, so the *_in ports still describe the pending instruction.
  - On mem_done: load the wb bundle as in IDLE, go to IDLE.
  - Otherwise: wb_valid=0 and counter increments.
  - If counter==TIMEOUT and mem_done=0: next edge sets err=1 and halted=1, state goes to HALT, request lines drop.
- IDLE, access & misalign: no memory request. Next edge: err=1, halted=1, HALT, wb_valid=0.
- IDLE, ex_valid & DMemDump_in:
  - mem_createdump=1 for exactly this cycle; stall_out=1.
  - Next edge: halted=1, HALT, wb_valid=0.
  - DMemEn_in is ignored for a dump.
- HALT: absorbing until rst.
  - stall_out=1, wb_valid=0, all memory request lines 0, err/halted held.
- ex_valid=0: no request and no dump, regardless of the control bits.
- mem_done outside an outstanding request: ignored.
- Every loaded wb_valid=1 corresponds to exactly one retired EX/MEM entry. There are no duplicates across stall cycles.
- Counter is 8 bits and saturates; it is cleared on entry to IDLE.

Test Plan:
1. ALU op: ex_valid=1, DMemEn=0, RegWrite=1, aluOutput=0x1234, WriteRegister=5 -> next cycle wb_valid=1, wb_aluOutput=0x1234, wb_WriteRegister=5, stall_out never 1.
2. Load with 3-cycle latency: addr=0x0040, mem_done on the 4th cycle, mem_rdata=0xBEEF.
   - Expect stall_out=1 for 3 cycles with mem_addr held at 0x0040 and mem_rd=1.
   - wb_valid=0 during the stall, then a single wb_valid=1 with wb_readData=0xBEEF and wb_MemToReg=1.
3. Zero-wait store: addr=0x0010, B=0xA5A5, mem_done=1 the same cycle -> mem_wr=1, mem_wdata=0xA5A5, stall_out=0, wb_valid=1 next cycle, wb_readData=0.
4. Errors:
   - Misaligned load at 0x0011 -> mem_rd stays 0, next cycle err=1 and halted=1.
   - Load with mem_done held 0 (TIMEOUT=16) -> err=1 on the cycle after counter hits 16, request lines drop, stall_out stays 1.
5. Dump: ex_valid=1, DMemDump=1 -> mem_createdump high for exactly 1 cycle, then halted=1, stall_out=1 permanently, later instructions produce no wb_valid.
6. Reset mid-WAIT: rst=1 on the 2nd wait cycle -> after the edge, state IDLE, mem_rd=0, stall_out=0, err=0, wb_valid=0. A following ALU op completes normally.
